// File: rtl/fetch_queue.sv
// Instruction-byte prefetch queue feeding the decoder: fetches one byte per
// memory handshake into a circular buffer and exposes a 4-byte window at the head.
module fetch_queue #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk2,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] eip,
  input  logic        consume,
  input  logic [3:0]  num_of_ope,
  output logic        busy,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;

  fetch_state_t   state, state_next;
  logic [7:0]     q [DEPTH];
  logic [AW-1:0]  head, tail;
  logic [CW-1:0]  count, count_next, pop_len;
  logic [31:0]    fetch_addr;
  logic [3:0]     pend_len, pend_next;
  logic           busy_next, err_next, push, pop;
  logic [31:0]    count_w, count_push_w, n_w, pend_w;

  // A fetched byte is only queued when no redirect flushes it on the same edge.
  assign push         = (state == REQ) && mem_ack && !redirect;
  assign count_w      = 32'(count);
  assign count_push_w = count_w + 32'(push);
  assign n_w          = 32'(num_of_ope);
  assign pend_w       = 32'(pend_len);
  assign mem_rd       = (state != IDLE);

  // Retire decision: either pop now, park the request as pending, or flag it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pop       = 1'b0;
    pop_len   = '0;
    busy_next = busy;
    pend_next = pend_len;
    err_next  = 1'b0;
    if (busy) begin
      if (count_push_w >= pend_w) begin
        pop       = 1'b1;
        pop_len   = CW'(pend_len);
        busy_next = 1'b0;
      end
      if (consume && num_of_ope != 4'd0) err_next = 1'b1;
    end else if (consume && num_of_ope != 4'd0) begin
      if (n_w > 32'(DEPTH)) begin
        err_next = 1'b1;
      end else if (count_w >= n_w) begin
        pop     = 1'b1;
        pop_len = CW'(num_of_ope);
      end else begin
        busy_next = 1'b1;
        pend_next = num_of_ope;
      end
    end
    if (redirect) begin
      pop       = 1'b0;
      pop_len   = '0;
      busy_next = 1'b0;
      err_next  = 1'b0;
    end
    count_next = redirect ? '0 : count + CW'(push) - pop_len;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (!redirect && count_w < 32'(DEPTH)) state_next = REQ;
      REQ: begin
        if (redirect)     state_next = mem_ack ? IDLE : DROP;
        else if (mem_ack) state_next = (32'(count_next) < 32'(DEPTH)) ? REQ : IDLE;
      end
      DROP: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      busy       <= 1'b0;
      pend_len   <= '0;
      err        <= 1'b0;
      eip        <= RESET_ADDR;
      fetch_addr <= RESET_ADDR;
      mem_addr   <= RESET_ADDR;
    end else begin
      state    <= state_next;
      count    <= count_next;
      busy     <= busy_next;
      pend_len <= pend_next;
      err      <= err_next;
      if (redirect) begin
        head       <= '0;
        tail       <= '0;
        eip        <= redirect_addr;
        fetch_addr <= redirect_addr;
      end else begin
        if (push) begin
          tail       <= tail + 1'b1;
          fetch_addr <= fetch_addr + 32'd1;
        end
        if (pop) begin
          head <= head + pop_len[AW-1:0];
          eip  <= eip + 32'(pop_len);
        end
      end
      // mem_addr stays frozen while a read (including a dropped one) is outstanding.
      if (state == IDLE && state_next == REQ)
        mem_addr <= fetch_addr;
      else if (push && state_next == REQ)
        mem_addr <= fetch_addr + 32'd1;
    end
  end

  // NOTE: the byte storage has no reset; count/head/tail alone define what is valid.
  always_ff @(posedge clk2) begin
    if (push) q[tail] <= mem_rdata;
  end

  always_comb begin
    ope = '0;
    for (int i = 0; i < 4; i++) begin
      if (CW'(i) < count) ope[31-8*i -: 8] = q[head + AW'(i)];
    end
  end

  assign ope_valid = (count >= CW'(4)) && !busy;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table for fetch/retire,
// then hand-written sequences for reset, full queue, redirect and address wrap.
module tb_fetch_queue;

  logic        clk2 = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [31:0] ope;
  logic        ope_valid;
  logic [31:0] eip;
  logic        consume;
  logic [3:0]  num_of_ope;
  logic        busy;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        err;

  fetch_queue #(.DEPTH(8), .RESET_ADDR(32'h0)) dut (
    .clk2(clk2), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ope(ope), .ope_valid(ope_valid),
    .eip(eip), .consume(consume), .num_of_ope(num_of_ope), .busy(busy),
    .redirect(redirect), .redirect_addr(redirect_addr), .err(err)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic        cons;
    logic [3:0]  n;
    logic        ack;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] ope;
    logic        valid;
    logic [31:0] eip;
    logic        busy;
    logic        err;
  } vec_t;

  logic [7:0] mem_img [16];
  vec_t       vecs [22];
  int         tests = 0;
  int         fails = 0;
  int         acks  = 0;
  logic       auto_ack  = 1'b0;
  logic       force_ack = 1'b0;

  function automatic vec_t mk(input logic cons, input logic [3:0] n, input logic ack,
                              input logic rd, input logic [31:0] addr, input logic [31:0] o,
                              input logic v, input logic [31:0] e, input logic b,
                              input logic er);
    vec_t r;
    r.cons = cons; r.n = n; r.ack = ack; r.rd = rd; r.addr = addr;
    r.ope = o; r.valid = v; r.eip = e; r.busy = b; r.err = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks in the cycle mem_rd is seen, data from a 16-byte image.
  task automatic cycle();
    mem_ack   = mem_rd && (auto_ack || force_ack);
    mem_rdata = mem_ack ? mem_img[mem_addr[3:0]] : 8'h00;
    if (mem_ack) acks++;
    @(posedge clk2);
    #1;
    consume    = 1'b0;
    num_of_ope = 4'd0;
    redirect   = 1'b0;
    force_ack  = 1'b0;
    mem_ack    = 1'b0;
  endtask

  initial begin
    mem_img = '{8'h55, 8'h89, 8'hE5, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h90, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};

    //              cons n   ack rd  addr      ope            v  eip     busy err
    vecs[0]  = mk(0, 0, 1, 1, 32'd0,  32'h0000_0000, 0, 32'd0,  0, 0);
    vecs[1]  = mk(0, 0, 1, 1, 32'd1,  32'h5500_0000, 0, 32'd0,  0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 32'd2,  32'h5589_0000, 0, 32'd0,  0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 32'd3,  32'h5589_E500, 0, 32'd0,  0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 32'd4,  32'h5589_E5B8, 1, 32'd0,  0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 32'd5,  32'h89E5_B801, 1, 32'd1,  0, 0);
    vecs[6]  = mk(0, 0, 1, 1, 32'd6,  32'h89E5_B801, 1, 32'd1,  0, 0);
    vecs[7]  = mk(0, 0, 1, 1, 32'd7,  32'h89E5_B801, 1, 32'd1,  0, 0);
    vecs[8]  = mk(0, 0, 1, 1, 32'd8,  32'h89E5_B801, 1, 32'd1,  0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 32'd8,  32'h89E5_B801, 1, 32'd1,  0, 0);
    vecs[10] = mk(0, 0, 1, 0, 32'd8,  32'h89E5_B801, 1, 32'd1,  0, 0);
    vecs[11] = mk(1, 2, 1, 0, 32'd8,  32'hB801_0000, 1, 32'd3,  0, 0);
    vecs[12] = mk(0, 0, 1, 1, 32'd9,  32'hB801_0000, 1, 32'd3,  0, 0);
    vecs[13] = mk(0, 0, 1, 1, 32'd10, 32'hB801_0000, 1, 32'd3,  0, 0);
    vecs[14] = mk(1, 5, 0, 1, 32'd10, 32'h90C3_0000, 0, 32'd8,  0, 0);
    vecs[15] = mk(1, 9, 0, 1, 32'd10, 32'h90C3_0000, 0, 32'd8,  0, 1);
    vecs[16] = mk(1, 0, 0, 1, 32'd10, 32'h90C3_0000, 0, 32'd8,  0, 0);
    vecs[17] = mk(1, 4, 0, 1, 32'd10, 32'h90C3_0000, 0, 32'd8,  1, 0);
    vecs[18] = mk(1, 1, 0, 1, 32'd10, 32'h90C3_0000, 0, 32'd8,  1, 1);
    vecs[19] = mk(0, 0, 1, 1, 32'd11, 32'h90C3_1100, 0, 32'd8,  1, 0);
    vecs[20] = mk(0, 0, 1, 1, 32'd12, 32'h0000_0000, 0, 32'd12, 0, 0);
    vecs[21] = mk(0, 0, 1, 1, 32'd13, 32'h3300_0000, 0, 32'd12, 0, 0);

    reset = 1'b0; consume = 1'b0; num_of_ope = 4'd0; redirect = 1'b0;
    redirect_addr = 32'h0; mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(posedge clk2);
    #1;
    check("reset mem_rd", 32'(mem_rd), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset eip", eip, 32'd0);
    check("reset ope_valid", 32'(ope_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err", 32'(err), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      consume    = vecs[i].cons;
      num_of_ope = vecs[i].n;
      auto_ack   = vecs[i].ack;
      cycle();
      check($sformatf("row%0d mem_rd", i), 32'(mem_rd), 32'(vecs[i].rd));
      check($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("row%0d ope", i), ope, vecs[i].ope);
      check($sformatf("row%0d ope_valid", i), 32'(ope_valid), 32'(vecs[i].valid));
      check($sformatf("row%0d eip", i), eip, vecs[i].eip);
      check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].err));
    end

    // Asynchronous reset between edges while a read is outstanding.
    check("pre-reset mem_rd", 32'(mem_rd), 32'd1);
    reset = 1'b0;
    #2;
    check("async reset mem_rd", 32'(mem_rd), 32'd0);
    check("async reset eip", eip, 32'd0);
    check("async reset mem_addr", mem_addr, 32'd0);
    check("async reset ope", ope, 32'd0);
    @(posedge clk2);
    #1;
    reset = 1'b1;

    // Full queue: exactly DEPTH acks, then a retire of 2 restarts at address 8.
    auto_ack = 1'b1;
    acks = 0;
    repeat (20) cycle();
    check("full acks", 32'(acks), 32'd8);
    check("full mem_rd", 32'(mem_rd), 32'd0);
    check("full ope", ope, 32'h5589_E5B8);
    consume = 1'b1; num_of_ope = 4'd2;
    cycle();
    check("full retire eip", eip, 32'd2);
    check("full retire ope", ope, 32'hE5B8_0100);
    cycle();
    check("refetch mem_rd", 32'(mem_rd), 32'd1);
    check("refetch mem_addr", mem_addr, 32'd8);

    // Redirect with the read held off for three cycles.
    auto_ack = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h100;
    cycle();
    check("drop eip", eip, 32'h100);
    check("drop ope_valid", 32'(ope_valid), 32'd0);
    check("drop ope", ope, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drop hold%0d mem_rd", k), 32'(mem_rd), 32'd1);
      check($sformatf("drop hold%0d mem_addr", k), mem_addr, 32'd8);
      if (k < 2) cycle();
    end
    force_ack = 1'b1;
    cycle();
    check("dropped byte mem_rd", 32'(mem_rd), 32'd0);
    check("dropped byte ope", ope, 32'd0);
    cycle();
    check("redirect req mem_rd", 32'(mem_rd), 32'd1);
    check("redirect req mem_addr", mem_addr, 32'h100);
    force_ack = 1'b1;
    cycle();
    check("redirect first byte", ope, 32'h5500_0000);
    check("redirect eip", eip, 32'h100);

    // Redirect coincident with an ack, then address wrap at 2^32.
    auto_ack = 1'b1;
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFE;
    cycle();
    check("wrap redirect mem_rd", 32'(mem_rd), 32'd0);
    check("wrap redirect eip", eip, 32'hFFFF_FFFE);
    check("wrap redirect ope", ope, 32'd0);
    cycle();
    check("wrap addr0", mem_addr, 32'hFFFF_FFFE);
    cycle();
    check("wrap addr1", mem_addr, 32'hFFFF_FFFF);
    cycle();
    check("wrap addr2", mem_addr, 32'h0000_0000);
    cycle();
    check("wrap addr3", mem_addr, 32'h0000_0001);
    check("wrap ope partial", ope, 32'h6677_5500);
    cycle();
    check("wrap ope full", ope, 32'h6677_5589);
    check("wrap ope_valid", 32'(ope_valid), 32'd1);
    consume = 1'b1; num_of_ope = 4'd3;
    cycle();
    check("wrap retire eip", eip, 32'h0000_0001);
    check("wrap retire ope", ope, 32'h89E5_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-byte prefetch stage sitting directly upstream of the decoder.
- Reads one opcode byte per memory handshake, buffers bytes in a circular queue, and presents a 4-byte window on ope with the head byte in ope[31:24].
- Retires the instruction length reported by the decoder (num_of_ope, 1..5 bytes).
- Supports flush/redirect for ret/jump.

Parameters:
- DEPTH, 8, queue depth in bytes; power of two, minimum 8.
- RESET_ADDR, 32'h00000000, eip and fetch address after reset.

Ports:
- clk2  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mem_addr  out  32  byte address of the outstanding read.
- mem_rd  out  1  read request; held with mem_addr stable until mem_ack.
- mem_rdata  in  8  read data, valid when mem_ack=1.
- mem_ack  in  1  single-cycle completion of the current read.
- ope  out  32  head 4 bytes, byte0 at [31:24]; slots beyond count read 8'h00.
- ope_valid  out  1  count>=4 and not busy.
- eip  out  32  address of the head byte (current instruction pointer).
- consume  in  1  retire pulse from decoder.
- num_of_ope  in  4  bytes to retire when consume=1.
- busy  out  1  a retire is pending for lack of bytes.
- redirect  in  1  flush and restart fetch.
- redirect_addr  in  32  new eip on redirect.
- err  out  1  one-cycle pulse on an illegal retire.

Behaviour:
- Reset (reset=0, asynchronous): mem_rd=0, mem_addr=RESET_ADDR, eip=RESET_ADDR, count=0, head=tail=0, busy=0, err=0, fetch FSM=IDLE. An outstanding read is abandoned. Outputs hold these values until the first clk2 edge after reset=1.
- Fetch FSM states are IDLE, REQ and DROP.
  - IDLE -> REQ when count + 1 <= DEPTH and redirect=0. Sets mem_rd=1, mem_addr=fetch_addr.
  - REQ with mem_ack: write mem_rdata at tail, tail++, count++, fetch_addr++. Stays in REQ (back-to-back; mem_addr advances next cycle) if room remains after this push; otherwise goes to IDLE with mem_rd=0.
  - At most one read is outstanding.
- Room check counts the in-flight byte: a request is issued only if count + in_flight < DEPTH.
- Retire handling when consume=1:
  - num_of_ope=0: ignored, no err.
  - num_of_ope>DEPTH: ignored, err=1 for one cycle.
  - busy=1: a second consume is ignored and err=1.
  - Else if count >= num_of_ope: head += n, count -= n, eip += n, all in the same edge.
  - Else busy=1: n is latched as pend_len and ope_valid=0. The pop executes on the first edge where count (including that edge's push) >= pend_len, then busy=0.
- Simultaneous push and pop on the same edge: count_next = count + 1 - n. Pointers wrap modulo DEPTH. Addresses wrap modulo 2^32 (eip, fetch_addr at 32'hFFFFFFFF -> 0).
- ope and ope_valid are combinational from registered queue state. They reflect the new head in the cycle after a pop, i.e. 1-cycle retire-to-window latency.
- Redirect has highest priority over consume and ack. On that edge:
  - count=0, head=tail=0, busy=0.
  - eip = fetch_addr = redirect_addr.
  - REQ with mem_ack same cycle: the byte is discarded; next state is IDLE.
  - REQ without mem_ack: next state is DROP, mem_rd stays 1 with the old address until ack, then the byte is discarded and the FSM goes to IDLE.
  - A redirect received while in DROP updates eip/fetch_addr only.
  - The first new-address request appears no earlier than the cycle after the FSM reaches IDLE.
- num_of_ope is sampled only when consume=1. err is a registered pulse.

Test Plan:
- Post-reset fetch:
  - Stimulus: memory at 0 holds 55 89 E5 B8 01 00 00 00, mem_ack one cycle after each mem_rd.
  - Required: mem_addr walks 0,1,2,...; after the 4th ack ope=32'h5589E5B8, ope_valid=1, eip=0.
- Single-byte retire:
  - Stimulus: consume, num_of_ope=1.
  - Required: next cycle ope=32'h89E5B801, eip=1, count decremented by 1 (plus any concurrent push).
- Full queue:
  - Stimulus: no consume, memory always acks.
  - Required: exactly 8 acks accepted; mem_rd=0 with count=8; the next consume of 2 restarts fetch at address 8.
- Under-run retire:
  - Stimulus: count=3, consume with num_of_ope=5 (B8 imm32).
  - Required: busy=1, ope_valid=0 until 2 more acks; then eip += 5, busy=0.
  - Follow-up: a consume during busy -> err pulse, ignored.
- Redirect with outstanding read:
  - Stimulus: redirect to 32'h100 while mem_rd=1 and ack is withheld 3 cycles.
  - Required: mem_addr holds its old value until ack; the returned byte is not queued; the next request is mem_addr=32'h100; eip=32'h100, ope_valid=0.
- Mid-operation reset and wrap:
  - Stimulus: reset=0 asserted between edges while mem_rd=1.
  - Required: mem_rd=0 and eip=RESET_ADDR immediately.
  - Also: with redirect_addr=32'hFFFFFFFE, fetch produces addresses FFFFFFFE, FFFFFFFF, 0, 1.
